datapath_sequencer: RTL and testbench

//  Multi-cycle control unit that sequences the register/ALU datapath: fetches an instruction word over a
//  req/valid handshake, decodes it, and drives the datapath's regWrite/ALUctrl/rs1/rs2/rd/ALUsrc/ImmOp.

---
 rtl/datapath_sequencer_pkg.sv | 15 +
 rtl/datapath_sequencer_if.sv | 24 ++
 rtl/datapath_sequencer_imm_gen.sv | 15 +
 rtl/datapath_sequencer.sv | 58 +++++
 tb/tb_datapath_sequencer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/datapath_sequencer_pkg.sv
// datapath_sequencer_pkg: shared state codes, opcode/funct3 fields and ALU op encodings
package datapath_sequencer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_EXEC  = 2'd2;
  localparam state_t S_HALT  = 2'd3;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: instruction-fetch handshake plus datapath control bundle
interface datapath_sequencer_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
);
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_valid;
  logic [31:0]        imem_rdata;
  logic               eq;
  logic               regWrite;
  logic [2:0]         ALUctrl;
  logic [A_WIDTH-1:0] rs1, rs2, rd;
  logic               ALUsrc;
  logic [D_WIDTH-1:0] ImmOp;
  modport master (
    output imem_req, imem_addr, regWrite, ALUctrl, rs1, rs2, rd, ALUsrc, ImmOp,
    input  imem_valid, imem_rdata, eq
  );
  modport slave (
    input  imem_req, imem_addr, regWrite, ALUctrl, rs1, rs2, rd, ALUsrc, ImmOp,
    output imem_valid, imem_rdata, eq
  );
endinterface

// File: rtl/datapath_sequencer_imm_gen.sv
// datapath_sequencer_imm_gen: sign-extended I or B immediate, chosen by opcode
module datapath_sequencer_imm_gen
  import datapath_sequencer_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [31:0]        ir,
  output logic [D_WIDTH-1:0] imm
);
  logic unused_ir;
  assign unused_ir = ^ir[19:12];
  assign imm = ir[6:0] == OPC_BRANCH
    ? {{(D_WIDTH-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0}
    : {{(D_WIDTH-12){ir[31]}}, ir[31:20]};
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/exec control FSM owning PC and IR, decoding ADD/ADDI/BNE
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int          A_WIDTH  = 5,
  parameter int          D_WIDTH  = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  datapath_sequencer_if.master bus,
  output logic [31:0]          pc,
  output logic                 halted,
  output logic                 illegal
);
  state_t state, state_n;
  logic [31:0] ir, next_pc;
  logic [D_WIDTH-1:0] imm;
  logic is_add, is_addi, is_bne, stop;
  datapath_sequencer_imm_gen #(.D_WIDTH(D_WIDTH)) u_imm (.ir(ir), .imm(imm));
  assign is_addi = ir[6:0] == OPC_OPIMM && ir[14:12] == F3_ADD;
  assign is_add  = ir[6:0] == OPC_OP && ir[14:12] == F3_ADD && ir[31:25] == 7'd0;
  assign is_bne  = ir[6:0] == OPC_BRANCH && ir[14:12] == F3_BNE;
  assign next_pc = is_bne && !bus.eq ? pc + 32'($signed(imm)) : pc + 32'd4;
  // IR==0 is not a legal encoding, so it also lands here; illegal separates the two
  assign stop = !(is_add || is_addi || is_bne) || next_pc[1:0] != 2'b00;
  always_comb
    state_n = state == S_IDLE  ? (run ? S_FETCH : S_IDLE) :
              state == S_FETCH ? (bus.imem_valid ? S_EXEC : S_FETCH) :
              state == S_EXEC  ? (stop ? S_HALT : run ? S_FETCH : S_IDLE) : S_HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_FETCH && bus.imem_valid) ir <= bus.imem_rdata;
      if (state == S_EXEC && !stop) pc <= next_pc;
      if (state == S_EXEC && stop) begin
        halted  <= 1'b1;
        illegal <= ir != 32'd0;
      end
    end
  end
  assign bus.imem_req  = state == S_FETCH;
  assign bus.imem_addr = pc;
  assign bus.regWrite  = state == S_EXEC && (is_add || is_addi) && ir[11:7] != 5'd0;
  assign bus.ALUctrl   = is_bne ? ALU_SUB : ALU_ADD;
  assign bus.ALUsrc    = is_addi;
  assign bus.ImmOp     = imm;
  assign bus.rs1       = A_WIDTH'(ir[19:15]);
  assign bus.rs2       = A_WIDTH'(ir[24:20]);
  assign bus.rd        = A_WIDTH'(ir[11:7]);
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed and randomized instruction streams against an ISA-level model
module tb_datapath_sequencer;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [31:0] pc;
  logic halted, illegal;
  logic [31:0] mpc;
  logic mhalt;
  int n_chk = 0, n_pass = 0;
  datapath_sequencer_if #(.A_WIDTH(5), .D_WIDTH(32)) bus ();
  datapath_sequencer #(.A_WIDTH(5), .D_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus), .pc(pc), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] b_imm(input logic [31:0] w);
    int v;
    v = w[31] ? -4096 : 0;
    v += int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    return 32'(v);
  endfunction
  function automatic logic [31:0] enc_bne(input logic [4:0] a, input logic [4:0] b, input logic [12:0] off);
    return {off[12], off[10:5], b, a, 3'b001, off[4:1], off[11], 7'b1100011};
  endfunction
  task automatic do_reset;
    rst = 1'b1; run = 1'b0; bus.imem_valid = 1'b0; bus.eq = 1'b0;
    @(negedge clk);
    rst = 1'b0; mpc = 32'h0; mhalt = 1'b0;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", 32'({halted, illegal}), 0);
    chk("rst_ctrl", 32'({bus.regWrite, bus.ALUctrl, bus.ALUsrc}), 0);
    run = 1'b1;
    @(negedge clk);
  endtask
  // Entered with the DUT in FETCH at a falling edge; leaves it in FETCH again unless halted
  task automatic step(input logic [31:0] w, input int waits, input logic eqv, input logic runv);
    logic add, addi, bne, halt;
    logic [31:0] imm, nxt;
    addi = w[6:0] == 7'h13 && w[14:12] == 3'd0;
    add  = w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0;
    bne  = w[6:0] == 7'h63 && w[14:12] == 3'd1;
    imm  = bne ? b_imm(w) : 32'($signed(w) >>> 20);
    nxt  = bne && !eqv ? mpc + imm : mpc + 32'd4;
    halt = !(add || addi || bne) || nxt % 4 != 0;
    for (int i = 0; i < waits; i++) begin
      chk("fetch_req", 32'(bus.imem_req), 1);
      chk("fetch_addr", bus.imem_addr, mpc);
      @(negedge clk);
    end
    chk("fetch_req", 32'(bus.imem_req), 1);
    chk("fetch_addr", bus.imem_addr, mpc);
    bus.imem_valid = 1'b1; bus.imem_rdata = w; bus.eq = eqv; run = runv;
    @(negedge clk);
    bus.imem_valid = 1'b0; bus.imem_rdata = $urandom;
    chk("exec_req", 32'(bus.imem_req), 0);
    chk("regwrite", 32'(bus.regWrite), 32'((add || addi) && w[11:7] != 5'd0));
    chk("regs", 32'({bus.rs1, bus.rs2, bus.rd}), 32'({w[19:15], w[24:20], w[11:7]}));
    if (addi || bne) chk("immop", bus.ImmOp, imm);
    if (add || addi || bne) chk("alu", 32'({bus.ALUsrc, bus.ALUctrl}), 32'({addi, bne ? 3'd1 : 3'd0}));
    @(negedge clk);
    if (halt) begin
      mhalt = 1'b1;
      chk("halt_flags", 32'({halted, illegal}), 32'({1'b1, w != 32'd0}));
      chk("halt_pc", pc, mpc);
      chk("halt_outs", 32'({bus.imem_req, bus.regWrite}), 0);
    end else begin
      mpc = nxt;
      chk("next_pc", pc, mpc);
      chk("post_exec", 32'({halted, bus.regWrite, bus.imem_req}), 32'(runv));
      if (!runv) begin
        bus.imem_valid = 1'b1; bus.imem_rdata = 32'h0000_0000;
        repeat (2) begin
          @(negedge clk);
          chk("idle_req", 32'(bus.imem_req), 0);
          chk("idle_ir", 32'(bus.rd), 32'(w[11:7]));
        end
        bus.imem_valid = 1'b0; run = 1'b1;
        @(negedge clk);
      end
    end
  endtask
  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  initial begin
    logic [31:0] w;
    logic [12:0] off;
    bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0; bus.eq = 1'b0;
    do_reset();
    rst = 1'b1; bus.imem_valid = 1'b1; bus.imem_rdata = ADDI_X1;
    @(negedge clk);
    rst = 1'b0; bus.imem_valid = 1'b0;
    chk("midfetch_rst", 32'({bus.imem_req, bus.regWrite, halted}), 0);
    chk("midfetch_pc", pc, 0);
    chk("midfetch_ir", 32'({bus.rs1, bus.rs2, bus.rd}), 0);
    @(negedge clk);
    step(ADDI_X1, 3, 1'b0, 1'b1);
    step(32'h0020_8033, 0, 1'b0, 1'b1);
    step(ADDI_X1, 0, 1'b0, 1'b1);
    step(ADDI_X1, 0, 1'b0, 1'b1);
    chk("at_0x10", pc, 32'h10);
    step(32'hFE20_9CE3, 1, 1'b0, 1'b1);
    chk("bne_taken", pc, 32'h08);
    step(ADDI_X1, 0, 1'b0, 1'b1);
    step(ADDI_X1, 0, 1'b0, 1'b1);
    step(32'hFE20_9CE3, 0, 1'b1, 1'b1);
    chk("bne_not_taken", pc, 32'h14);
    step(ADDI_X1, 2, 1'b0, 1'b0);
    step(32'hFFFF_FFFF, 0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("halt_sticky", 32'({bus.imem_req, halted, illegal}), 32'b011);
      chk("halt_pc_hold", pc, 32'h18);
    end
    do_reset();
    step(32'h0, 0, 1'b0, 1'b1);
    do_reset();
    step(enc_bne(5'd1, 5'd2, 13'd6), 0, 1'b0, 1'b1);
    do_reset();
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
        4, 5: w = {7'b0, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011};
        6, 7, 8: begin
          off = 13'($urandom) & 13'h1FFE;
          if ($urandom_range(0, 7) != 0) off[1] = 1'b0;
          w = enc_bne(5'($urandom), 5'($urandom), off);
        end
        default: w = $urandom;
      endcase
      step(w, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 5) != 0);
      if (mhalt) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
